bg_tile_fetch: RTL and testbench



---
 rtl/bg_tile_fetch.sv | 205 ++++++++++++++++++++
 tb/tb_bg_tile_fetch.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_tile_fetch.sv
// bg_tile_fetch: background tile fetch stage.
// Walks the tile columns of one scanline, reads packed name table words
// (4 tile indices per word) plus the matching attribute word, and emits one
// {tile index, palette, column, fine row} record per tile.
// Optional build macro: BG_SCROLL_EN (adds scroll_tile_x coarse horizontal scroll).
//
// Handshake: a record is transferred on a clock edge where out_valid and
// out_ready are both high; while out_valid is high and out_ready low, every
// out_* field holds steady; out_ready is don't-care when out_valid is low.
module bg_tile_fetch #(
  parameter int ADDR_W    = 9,
  parameter int ATTR_BASE = 240,
  parameter int TILES_X   = 32,
  parameter int LINES     = 240
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_start,
  input  logic [7:0]        line_y,
`ifdef BG_SCROLL_EN
  input  logic [4:0]        scroll_tile_x,
`endif
  output logic [ADDR_W-1:0] nameTableRamIndex,
  input  logic [31:0]       nameTableRamDataO,
  output logic [8:0]        attributeAddr,
  input  logic [31:0]       attributeTableDataO,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_tile_idx,
  output logic [1:0]        out_palette,
  output logic [4:0]        out_tile_col,
  output logic [2:0]        out_fine_y,
  output logic              busy,
  output logic              line_done
);

  localparam int         WPR       = TILES_X / 4;   // name table words per tile row
  localparam logic [4:0] LAST_COL  = 5'(TILES_X - 1);
  localparam logic [8:0] LINES_LIM = 9'(LINES);

  typedef enum logic [2:0] {IDLE, RD, CAP, EMIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  row_q, row_nxt;        // tile row = line_y[7:3]
  logic [2:0]  fine_q, fine_nxt;      // row within tile
  logic [4:0]  col_q, col_nxt;        // screen column of the current record
  logic [4:0]  scroll_q, scroll_nxt;  // coarse scroll captured at line start
  logic [4:0]  scroll_in;
  logic        load_addr;             // high when the next state is RD
  logic [4:0]  col_inc, fcol, fcol_nxt, fcol_inc;
  logic [31:0] name_q, attr_q;
  logic [ADDR_W-1:0] name_addr_q;
  logic [8:0]  attr_addr_q;
  logic [7:0]  ab_idx, attr_byte;
  logic [1:0]  quad;

`ifdef BG_SCROLL_EN
  assign scroll_in = scroll_tile_x;
`else
  assign scroll_in = 5'd0;
`endif

  function automatic logic [ADDR_W-1:0] name_addr(input logic [4:0] row, input logic [2:0] wc);
    name_addr = ADDR_W'(row) * ADDR_W'(WPR) + ADDR_W'(wc);
  endfunction

  // Attribute byte index: 4-row band times bytes-per-band plus 4-column group.
  function automatic logic [7:0] attr_byte_idx(input logic [2:0] band, input logic [2:0] wc);
    attr_byte_idx = 8'(band) * 8'(WPR) + 8'(wc);
  endfunction

  function automatic logic [8:0] attr_addr(input logic [2:0] band, input logic [2:0] wc);
    logic [7:0] b;
    b = attr_byte_idx(band, wc);
    attr_addr = 9'(ATTR_BASE) + 9'(b[7:2]);
  endfunction

  // Lanes are MSB-first: lane 0 is bits [31:24].
  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] lane);
    case (lane)
      2'd0:    lane_byte = w[31:24];
      2'd1:    lane_byte = w[23:16];
      2'd2:    lane_byte = w[15:8];
      default: lane_byte = w[7:0];
    endcase
  endfunction

  assign col_inc  = col_q + 5'd1;
  assign fcol     = col_q + scroll_q;
  assign fcol_inc = col_inc + scroll_q;

  // Next-state logic: a new RD/CAP pair is needed at every group start and,
  // with scrolling, whenever the next fetch column crosses into a new word.
  always_comb begin
    state_nxt  = state;
    row_nxt    = row_q;
    fine_nxt   = fine_q;
    col_nxt    = col_q;
    scroll_nxt = scroll_q;
    load_addr  = 1'b0;
    case (state)
      IDLE: begin
        if (line_start && ({1'b0, line_y} < LINES_LIM)) begin
          state_nxt  = RD;
          row_nxt    = line_y[7:3];
          fine_nxt   = line_y[2:0];
          col_nxt    = 5'd0;
          scroll_nxt = scroll_in;
          load_addr  = 1'b1;
        end
      end
      RD:  state_nxt = CAP;
      CAP: state_nxt = EMIT;
      EMIT: begin
        if (out_ready) begin
          if (col_q == LAST_COL) begin
            state_nxt = DONE;
          end else begin
            col_nxt = col_inc;
            if (col_q[1:0] == 2'd3 || fcol_inc[1:0] == 2'd0) begin
              state_nxt = RD;
              load_addr = 1'b1;
            end
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    fcol_nxt = col_nxt + scroll_nxt;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Per-line context: row, fine row, column and scroll.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q    <= 5'd0;
      fine_q   <= 3'd0;
      col_q    <= 5'd0;
      scroll_q <= 5'd0;
    end else begin
      row_q    <= row_nxt;
      fine_q   <= fine_nxt;
      col_q    <= col_nxt;
      scroll_q <= scroll_nxt;
    end
  end

  // RAM addresses are registered on entry to RD so they are stable during RD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      name_addr_q <= '0;
      attr_addr_q <= 9'd0;
    end else if (load_addr) begin
      name_addr_q <= name_addr(row_nxt, fcol_nxt[4:2]);
      attr_addr_q <= attr_addr(row_nxt[4:2], fcol_nxt[4:2]);
    end
  end

  // Capture both RAM words one cycle after the address was presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      name_q <= 32'd0;
      attr_q <= 32'd0;
    end else if (state == CAP) begin
      name_q <= nameTableRamDataO;
      attr_q <= attributeTableDataO;
    end
  end

  assign nameTableRamIndex = name_addr_q;
  assign attributeAddr     = attr_addr_q;
  assign ab_idx            = attr_byte_idx(row_q[4:2], fcol[4:2]);
  assign attr_byte         = lane_byte(attr_q, ab_idx[1:0]);
  assign quad              = {row_q[1], fcol[1]};

  // Record outputs are held at zero except while a record is being offered.
  always_comb begin
    out_valid    = 1'b0;
    out_tile_idx = 8'd0;
    out_palette  = 2'd0;
    out_tile_col = 5'd0;
    out_fine_y   = 3'd0;
    busy         = (state == RD) || (state == CAP) || (state == EMIT);
    line_done    = (state == DONE);
    if (state == EMIT) begin
      out_valid    = 1'b1;
      out_tile_idx = lane_byte(name_q, fcol[1:0]);
      out_tile_col = col_q;
      out_fine_y   = fine_q;
      case (quad)
        2'd0:    out_palette = attr_byte[1:0];
        2'd1:    out_palette = attr_byte[3:2];
        2'd2:    out_palette = attr_byte[5:4];
        default: out_palette = attr_byte[7:6];
      endcase
    end
  end

endmodule

// File: tb/tb_bg_tile_fetch.sv
// Testbench for bg_tile_fetch: RAM model, record scoreboard, directed steps.
module tb_bg_tile_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        line_start;
  logic [7:0]  line_y;
`ifdef BG_SCROLL_EN
  logic [4:0]  scroll_tile_x;
`endif
  logic [8:0]  nameTableRamIndex;
  logic [31:0] nameTableRamDataO;
  logic [8:0]  attributeAddr;
  logic [31:0] attributeTableDataO;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_tile_idx;
  logic [1:0]  out_palette;
  logic [4:0]  out_tile_col;
  logic [2:0]  out_fine_y;
  logic        busy;
  logic        line_done;

  int pass_cnt = 0;
  int total_cnt = 0;
  int fail_cnt = 0;
  int rec_cnt = 0;
  int ld_cnt = 0;

  logic [31:0] mem [0:511];
  logic [17:0] exp_q[$];
  logic [17:0] acc_q[$];
  logic [8:0]  addr_log[$];
  logic        prev_stall = 1'b0;
  logic [17:0] prev_rec = '0;

  bg_tile_fetch dut (
    .clk                 (clk),
    .rst                 (rst),
    .line_start          (line_start),
    .line_y              (line_y),
`ifdef BG_SCROLL_EN
    .scroll_tile_x       (scroll_tile_x),
`endif
    .nameTableRamIndex   (nameTableRamIndex),
    .nameTableRamDataO   (nameTableRamDataO),
    .attributeAddr       (attributeAddr),
    .attributeTableDataO (attributeTableDataO),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_tile_idx        (out_tile_idx),
    .out_palette         (out_palette),
    .out_tile_col        (out_tile_col),
    .out_fine_y          (out_fine_y),
    .busy                (busy),
    .line_done           (line_done)
  );

  // Clock
  always #5 clk = ~clk;

  // RAM read ports: data valid one cycle after address.
  always @(posedge clk) begin
    nameTableRamDataO   <= mem[nameTableRamIndex];
    attributeTableDataO <= mem[attributeAddr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: record for screen column col of line y with coarse scroll s.
  function automatic logic [17:0] exp_rec(input int y, input int col, input int s);
    int row, fc, b, q;
    logic [31:0] w, aw;
    logic [7:0] tile, ab;
    logic [1:0] pal;
    logic [4:0] c5;
    logic [2:0] f3;
    row  = y / 8;
    fc   = (col + s) % 32;
    w    = mem[row * 8 + fc / 4];
    tile = 8'((w >> (8 * (3 - fc % 4))) & 32'hff);
    b    = (row / 4) * 8 + fc / 4;
    aw   = mem[240 + b / 4];
    ab   = 8'((aw >> (8 * (3 - b % 4))) & 32'hff);
    q    = ((row / 2) % 2) * 2 + (fc / 2) % 2;
    pal  = 2'((ab >> (2 * q)) & 8'd3);
    c5   = 5'(col);
    f3   = 3'(y % 8);
    return {tile, pal, c5, f3};
  endfunction

  // Scoreboard / monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [17:0] cur;
    if (!rst) begin
      cur = {out_tile_idx, out_palette, out_tile_col, out_fine_y};
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_hold", 32'(cur), 32'(prev_rec));
      end
      if (out_valid && out_ready) begin
        rec_cnt++;
        acc_q.push_back(cur);
        if (exp_q.size() == 0) check("extra_record", 32'(exp_q.size()), 32'd1);
        else check("record", 32'(cur), 32'(exp_q.pop_front()));
      end
      prev_stall = out_valid && !out_ready;
      prev_rec   = cur;
      if (line_done) ld_cnt++;
      if (busy && (addr_log.size() == 0 || addr_log[$] != nameTableRamIndex))
        addr_log.push_back(nameTableRamIndex);
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic start_line(input int y, input int s);
    if (y < 240) for (int c = 0; c < 32; c++) exp_q.push_back(exp_rec(y, c, s));
    line_y = 8'(y);
`ifdef BG_SCROLL_EN
    scroll_tile_x = 5'(s);
`endif
    @(posedge clk); #1 line_start = 1'b1;
    @(posedge clk); #1 line_start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input bit rnd_ready, output int cyc);
    cyc = 0;
    while (cyc < max_cyc) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
      if (line_done) break;
    end
    check("line_done_seen", 32'(line_done), 32'd1);
    out_ready = 1'b1;
  endtask

  initial begin
    int cyc, ld0, rc0, base;
    logic [17:0] r;
    rst = 1'b1; line_start = 1'b0; line_y = 8'd0; out_ready = 1'b1;
`ifdef BG_SCROLL_EN
    scroll_tile_x = 5'd0;
`endif
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    mem[0]   = 32'h11223344;
    mem[240] = 32'hE4000000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_name_addr", 32'(nameTableRamIndex), 32'd0);
    check("rst_attr_addr", 32'(attributeAddr), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_line_done", 32'(line_done), 32'd0);
    check("rst_record", 32'({out_tile_idx, out_palette, out_tile_col, out_fine_y}), 32'd0);
    @(negedge clk) rst = 1'b0;

    // Line 0, ready held high: fixed latency and known tile/palette values.
    acc_q.delete();
    start_line(0, 0);
    wait_done(200, 1'b0, cyc);
    check("line_cycles", 32'(cyc), 32'd48);
    @(negedge clk); #1;
    check("line0_empty", 32'(exp_q.size()), 32'd0);
    check("line0_count", 32'(acc_q.size()), 32'd32);
    check("line_done_cnt", 32'(ld_cnt), 32'd1);
    for (int i = 0; i < 4; i++) begin
      r = acc_q[i];
      check("l0_tile", 32'(r[17:10]), 32'(8'h11 * (i + 1)));
      check("l0_pal", 32'(r[9:8]), (i < 2) ? 32'd0 : 32'd1);
      check("l0_fine", 32'(r[2:0]), 32'd0);
    end

    // Line 13: name table address sequence 8..15.
    addr_log.delete();
    start_line(13, 0);
    wait_done(200, 1'b0, cyc);
    @(negedge clk); #1;
    check("l13_addr_cnt", 32'(addr_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < addr_log.size(); i++)
      check("l13_addr", 32'(addr_log[i]), 32'(8 + i));
    check("l13_empty", 32'(exp_q.size()), 32'd0);

    // Random backpressure on random lines.
    for (int n = 0; n < 4; n++) begin
      start_line($urandom_range(0, 239), 0);
      wait_done(600, 1'b1, cyc);
      @(negedge clk); #1;
      check("rnd_empty", 32'(exp_q.size()), 32'd0);
    end

    // line_start while busy and with an out-of-range line are ignored.
    ld0 = ld_cnt;
    start_line(50, 0);
    repeat (5) @(posedge clk);
    #1 line_y = 8'd200; line_start = 1'b1;
    @(posedge clk); #1 line_start = 1'b0;
    wait_done(200, 1'b0, cyc);
    @(negedge clk); #1;
    check("busy_ign_empty", 32'(exp_q.size()), 32'd0);
    check("busy_ign_ld", 32'(ld_cnt), 32'(ld0 + 1));
    rc0 = rec_cnt;
    start_line(240, 0);
    repeat (60) @(posedge clk);
    #1;
    check("y240_busy", 32'(busy), 32'd0);
    check("y240_ld", 32'(ld_cnt), 32'(ld0 + 1));
    check("y240_recs", 32'(rec_cnt), 32'(rc0));

    // Reset while tile 10 is being offered.
    ld0 = ld_cnt;
    base = rec_cnt;
    start_line(20, 0);
    cyc = 0;
    while (cyc < 200 && rec_cnt - base < 10) begin
      @(posedge clk); #2;
      cyc++;
    end
    check("mid_valid", 32'(out_valid), 32'd1);
    check("mid_col", 32'(out_tile_col), 32'd10);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(line_done), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    check("mid_rst_ld", 32'(ld_cnt), 32'(ld0));
    acc_q.delete();
    start_line(21, 0);
    wait_done(200, 1'b0, cyc);
    @(negedge clk); #1;
    check("post_rst_empty", 32'(exp_q.size()), 32'd0);
    check("post_rst_cnt", 32'(acc_q.size()), 32'd32);

`ifdef BG_SCROLL_EN
    // Coarse scroll 6 on line 0, then random scrolls with backpressure.
    acc_q.delete();
    start_line(0, 6);
    wait_done(600, 1'b1, cyc);
    @(negedge clk); #1;
    check("scr_empty", 32'(exp_q.size()), 32'd0);
    if (acc_q.size() == 32) begin
      r = acc_q[0];
      check("scr_col0", 32'(r[17:10]), 32'(mem[1][15:8]));
      r = acc_q[26];
      check("scr_col26", 32'(r[17:10]), 32'(mem[0][31:24]));
    end
    for (int n = 0; n < 3; n++) begin
      start_line($urandom_range(0, 239), $urandom_range(0, 31));
      wait_done(600, 1'b1, cyc);
      @(negedge clk); #1;
      check("scr_rnd_empty", 32'(exp_q.size()), 32'd0);
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
